// File: rtl/pwm_decode.sv
// pwm_decode: measures an incoming PWM waveform. Reports the period and the
// high time in clk cycles, with a one-cycle vld strobe per completed period.
// If no rising edge arrives within TIMEOUT cycles, it raises a sticky timeout
// flag and records the stuck line level.
module pwm_decode #(
    parameter int PW      = 21,
    parameter int DW      = 20,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PWM_in,
    output logic [PW-1:0] period,
    output logic [DW-1:0] high_time,
    output logic          vld,
    output logic          timeout,
    output logic          stuck_lvl
);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEAS_HI   = 2'd1,
        MEAS_LO   = 2'd2
    } state_t;

    localparam logic [PW-1:0] TO      = PW'(TIMEOUT);
    localparam logic [PW-1:0] PER_MAX = '1;
    localparam logic [DW-1:0] HI_MAX  = '1;

    state_t        state;
    logic          s1, s2, s3;
    logic [PW-1:0] per_cnt;
    logic [DW-1:0] hi_cnt;
    logic [PW-1:0] idle_cnt;
    logic          rise, fall;
    logic [PW-1:0] per_inc;
    logic [DW-1:0] hi_inc;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    // Both counters clamp at all-ones instead of wrapping.
    assign per_inc = (per_cnt == PER_MAX) ? per_cnt : per_cnt + 1'b1;
    assign hi_inc  = (hi_cnt == HI_MAX) ? hi_cnt : hi_cnt + 1'b1;

    // Two-flop synchronizer, plus a history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PWM_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Measurement FSM. All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_EDGE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            idle_cnt  <= '0;
            period    <= '0;
            high_time <= '0;
            vld       <= 1'b0;
            timeout   <= 1'b0;
            stuck_lvl <= 1'b0;
        end else begin
            vld <= 1'b0;
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        // First edge after reset or timeout. It starts a
                        // measurement but does not report one.
                        per_cnt  <= PW'(1);
                        hi_cnt   <= DW'(1);
                        idle_cnt <= '0;
                        timeout  <= 1'b0;
                        state    <= MEAS_HI;
                    end else if (idle_cnt >= TO) begin
                        // Capture the level only once per stuck episode.
                        if (!timeout) begin
                            timeout   <= 1'b1;
                            stuck_lvl <= s2;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                MEAS_HI: begin
                    // A rising edge cannot occur here, because a fall
                    // always comes first.
                    if (per_cnt >= TO) begin
                        timeout   <= 1'b1;
                        stuck_lvl <= s2;
                        idle_cnt  <= '0;
                        state     <= WAIT_EDGE;
                    end else begin
                        per_cnt <= per_inc;
                        // The fall cycle is already low, so it is not added
                        // to the high time.
                        if (fall) state <= MEAS_LO;
                        else      hi_cnt <= hi_inc;
                    end
                end
                MEAS_LO: begin
                    // If a rise and the timeout limit occur in the same
                    // cycle, the rise wins and a normal measurement is reported.
                    if (rise) begin
                        period    <= per_cnt;
                        high_time <= hi_cnt;
                        vld       <= 1'b1;
                        per_cnt   <= PW'(1);
                        hi_cnt    <= DW'(1);
                        state     <= MEAS_HI;
                    end else if (per_cnt >= TO) begin
                        timeout   <= 1'b1;
                        stuck_lvl <= s2;
                        idle_cnt  <= '0;
                        state     <= WAIT_EDGE;
                    end else begin
                        per_cnt <= per_inc;
                    end
                end
                default: state <= WAIT_EDGE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_decode.sv
// tb_pwm_decode: directed stimulus with a scoreboard of expected
// period/high_time pairs. An entry is pushed each time a rise closes a
// complete period, and it is popped and compared when vld fires.
module tb_pwm_decode;

    localparam int PW = 21;
    localparam int DW = 20;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PWM_in = 1'b0;
    logic [PW-1:0] period;
    logic [DW-1:0] high_time;
    logic          vld;
    logic          timeout;
    logic          stuck_lvl;

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   have_prev = 0;
    int   prev_p, prev_h;
    logic vld_d = 1'b0;

    pwm_decode #(.PW(PW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .PWM_in    (PWM_in),
        .period    (period),
        .high_time (high_time),
        .vld       (vld),
        .timeout   (timeout),
        .stuck_lvl (stuck_lvl)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every vld must match the oldest expectation.
    always @(negedge clk) begin
        if (vld) begin
            n_assert++;
            assert (vld_d === 1'b0) else begin
                n_fail++; $error("FAIL vld_consec observed=two-cycle vld expected=single");
            end
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++; $error("FAIL unexpected_vld observed period=%0d high=%0d expected=no vld", period, high_time);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_assert++;
                assert (period === PW'(e.p)) else begin
                    n_fail++; $error("FAIL period observed=%0d expected=%0d", period, e.p);
                end
                n_assert++;
                assert (high_time === DW'(e.h)) else begin
                    n_fail++; $error("FAIL high_time observed=%0d expected=%0d", high_time, e.h);
                end
            end
        end
        vld_d = vld;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rise now. If this closes a known period, queue its measurement.
    task automatic rise_edge();
        if (have_prev) sb.push_back('{prev_p, prev_h});
        PWM_in = 1'b1;
    endtask

    // One full PWM period: h cycles high, then p-h cycles low.
    task automatic drive_period(input int h, input int p);
        rise_edge();
        wait_cyc(h);
        PWM_in = 1'b0;
        wait_cyc(p - h);
        prev_p = p; prev_h = h; have_prev = 1;
    endtask

    // Wait, with a bound, for timeout; check the delay and the stuck level.
    task automatic wait_timeout(input string tag, input logic lvl, input int lo, input int hi);
        int cnt = 0;
        while (timeout !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_timeout"}, 32'(timeout), 32'd1);
        n_assert++;
        assert (cnt >= lo && cnt <= hi) else begin
            n_fail++; $error("FAIL %s_delay observed=%0d expected=%0d..%0d", tag, cnt, lo, hi);
        end
        check({tag, "_stuck_lvl"}, 32'(stuck_lvl), 32'(lvl));
        have_prev = 0;
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high", 32'(high_time), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_stuck", 32'(stuck_lvl), 32'd0);
        rst = 1'b0;

        // Line stuck low from reset
        wait_timeout("stuck0", 1'b0, 95, 110);

        // Steady 10/3 square wave. The first rise clears timeout and gives no vld.
        for (int i = 0; i < 6; i++) drive_period(3, 10);
        check("clear_timeout", 32'(timeout), 32'd0);

        // Mid-stream switch to 25/12
        for (int i = 0; i < 4; i++) drive_period(12, 25);

        // Rise lands exactly on the TIMEOUT count: the rise wins
        drive_period(30, TO);
        drive_period(3, 10);
        check("edge_timeout", 32'(timeout), 32'd0);
        drive_period(3, 10);

        // Stuck high after a rise; the last measurement must hold
        rise_edge();
        have_prev = 0;
        wait_timeout("stuck1", 1'b1, 95, 110);
        check("hold_period", 32'(period), 32'd10);
        check("hold_high", 32'(high_time), 32'd3);
        PWM_in = 1'b0;
        wait_cyc(5);
        for (int i = 0; i < 3; i++) drive_period(4, 12);
        check("clear_timeout2", 32'(timeout), 32'd0);

        // Reset during a high phase
        rise_edge();
        wait_cyc(5);
        check("pre_rst_sb_empty", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_period", 32'(period), 32'd0);
        check("mid_rst_high", 32'(high_time), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_vld", 32'(vld), 32'd0);
        wait_cyc(3);
        PWM_in = 1'b0;
        rst = 1'b0;
        have_prev = 0;
        wait_cyc(4);
        for (int i = 0; i < 3; i++) drive_period(5, 16);
        rise_edge();
        have_prev = 0;
        wait_cyc(6);
        PWM_in = 1'b0;
        wait_cyc(5);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
